// File: rtl/res_drain_ctrl_if.sv
// Response-drain handshake bundle: Res_fifo read side plus the byte stream to the UART.
// master = drain controller, slave = FIFO/UART side.
interface res_drain_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             fifo_eflag;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_ren;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;

   modport master (
      input  fifo_eflag,
      input  fifo_rdata,
      input  tx_ready,
      output fifo_ren,
      output tx_data,
      output tx_valid
   );

   modport slave (
      output fifo_eflag,
      output fifo_rdata,
      output tx_ready,
      input  fifo_ren,
      input  tx_data,
      input  tx_valid
   );
endinterface

// File: rtl/res_drain_ctrl.sv
// Drains WIDTH-bit response words from Res_fifo and streams them byte by byte to a UART
// transmitter, with back-to-back word reads and a running count of completed words.
module res_drain_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic                  r_clk,
   input  logic                  reset,
   input  logic                  en,
   res_drain_ctrl_if.master      bus,
   output logic                  busy,
   output logic [15:0]           words_sent
);

   localparam int unsigned NB = WIDTH / 8;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   if (((WIDTH % 8) != 0) || (WIDTH < 8)) begin : g_bad_width
      $error("res_drain_ctrl: WIDTH must be a non-zero multiple of 8");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    sel;
   logic [15:0]      words_q;
   logic             armed_q;
   logic             xfer;
   logic             last_xfer;
   logic             can_read;

   // armed_q holds off any read until the first clock edge after reset release.
   assign can_read  = armed_q && en && !bus.fifo_eflag;
   assign xfer      = (state_q == SEND) && bus.tx_ready;
   assign last_xfer = xfer && (idx_q == LAST_IDX);

   always_comb begin
      state_d      = state_q;
      bus.fifo_ren = 1'b0;
      case (state_q)
         IDLE: begin
            if (can_read) begin
               bus.fifo_ren = 1'b1;
               state_d      = RD;
            end
         end
         RD:   state_d = LOAD;
         LOAD: state_d = SEND;
         SEND: begin
            if (last_xfer) begin
               if (can_read) begin
                  bus.fifo_ren = 1'b1;
                  state_d      = RD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge r_clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         words_q <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         if (state_q == LOAD) begin
            hold_q <= bus.fifo_rdata;
            idx_q  <= '0;
         end else if (xfer && !last_xfer) begin
            idx_q <= idx_q + 1'b1;
         end
         if (last_xfer) begin
            words_q <= words_q + 16'd1;
         end
      end
   end

   // Byte order is fixed by the word layout; LSB_FIRST only mirrors the index.
   assign sel          = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
   assign bus.tx_data  = 8'(hold_q >> {sel, 3'b000});
   assign bus.tx_valid = (state_q == SEND);
   assign busy         = (state_q != IDLE);
   assign words_sent   = words_q;

endmodule

// File: tb/tb_res_drain_ctrl.sv
// Directed bench for res_drain_ctrl: LSB-first and MSB-first instances, each fed by a
// small behavioural Res_fifo model.
module tb_res_drain_ctrl;
   logic        r_clk = 1'b0;
   logic        reset;
   logic        en;
   logic        busy, busy_m;
   logic [15:0] words_sent, words_sent_m;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   res_drain_ctrl_if #(.WIDTH(32)) bus ();
   res_drain_ctrl_if #(.WIDTH(32)) bus_m ();

   res_drain_ctrl #(.WIDTH(32), .LSB_FIRST(1'b1)) dut (
      .r_clk(r_clk), .reset(reset), .en(en), .bus(bus),
      .busy(busy), .words_sent(words_sent)
   );

   res_drain_ctrl #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_m (
      .r_clk(r_clk), .reset(reset), .en(en), .bus(bus_m),
      .busy(busy_m), .words_sent(words_sent_m)
   );

   always #5 r_clk = ~r_clk;

   // FIFO model for the LSB-first instance: data appears the edge after fifo_ren.
   logic [31:0] mem [0:15];
   int unsigned wp = 0;
   int unsigned rp = 0;
   assign bus.fifo_eflag = (wp == rp);
   always @(posedge r_clk) begin
      if (bus.fifo_ren) begin
         bus.fifo_rdata <= mem[rp[3:0]];
         rp <= rp + 1;
      end
   end

   logic [31:0] m_word;
   int unsigned m_wr = 0;
   int unsigned m_rd = 0;
   assign bus_m.fifo_eflag = (m_wr == m_rd);
   always @(posedge r_clk) begin
      if (bus_m.fifo_ren) begin
         bus_m.fifo_rdata <= m_word;
         m_rd <= m_rd + 1;
      end
   end

   task automatic test_reset();
      mem[0] = 32'hA1B2C3D4;
      wp = 1;
      en = 1'b1;
      repeat (3) @(negedge r_clk);
      #1;
      n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL rst_ren got %b exp 0", bus.fifo_ren); end
      n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.tx_valid); end
      n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", bus.tx_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_checks++; if (words_sent !== 16'h0000) begin n_fail++; $display("FAIL rst_words got %h exp 0000", words_sent); end
      @(negedge r_clk);
      reset = 1'b1;
      #1;
      n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL rel_ren_early got %b exp 0", bus.fifo_ren); end
      @(posedge r_clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_busy got %b exp 0", busy); end
      n_checks++; if (bus.fifo_ren !== 1'b1) begin n_fail++; $display("FAIL rel_ren_armed got %b exp 1", bus.fifo_ren); end
      en = 1'b0;
      @(negedge r_clk);
      #1;
      n_checks++; if (rp !== 0) begin n_fail++; $display("FAIL rel_no_read rp got %0d exp 0", rp); end
   endtask

   task automatic test_lsb_word();
      logic [7:0] e_ren  = 8'b0000_0001;
      logic [7:0] e_val  = 8'b0111_1000;
      logic [7:0] e_busy = 8'b0111_1110;
      logic [7:0] e_d [8] = '{8'h00, 8'h00, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00};
      @(negedge r_clk);
      bus.tx_ready = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_checks++; if (bus.fifo_ren !== e_ren[c]) begin n_fail++; $display("FAIL lsb_ren c=%0d got %b exp %b", c, bus.fifo_ren, e_ren[c]); end
         n_checks++; if (bus.tx_valid !== e_val[c]) begin n_fail++; $display("FAIL lsb_valid c=%0d got %b exp %b", c, bus.tx_valid, e_val[c]); end
         n_checks++; if (busy !== e_busy[c]) begin n_fail++; $display("FAIL lsb_busy c=%0d got %b exp %b", c, busy, e_busy[c]); end
         if (e_val[c]) begin
            n_checks++; if (bus.tx_data !== e_d[c]) begin n_fail++; $display("FAIL lsb_data c=%0d got %h exp %h", c, bus.tx_data, e_d[c]); end
         end
         if (c < 7) @(negedge r_clk);
      end
      n_checks++; if (words_sent !== 16'd1) begin n_fail++; $display("FAIL lsb_words got %0d exp 1", words_sent); end
   endtask

   task automatic test_msb_stall();
      logic [7:0] e_d [7] = '{8'hA1, 8'hB2, 8'hB2, 8'hC3, 8'hC3, 8'hD4, 8'hD4};
      int k = 0;
      @(negedge r_clk);
      m_word = 32'hA1B2C3D4;
      m_wr = 1;
      bus_m.tx_ready = 1'b0;
      #1;
      while (!bus_m.tx_valid && k < 10) begin
         @(negedge r_clk);
         #1;
         k++;
      end
      n_checks++; if (bus_m.tx_valid !== 1'b1) begin n_fail++; $display("FAIL msb_start got %b exp 1", bus_m.tx_valid); end
      n_checks++; if (k !== 3) begin n_fail++; $display("FAIL msb_latency got %0d exp 3", k); end
      for (int s = 0; s < 7; s++) begin
         bus_m.tx_ready = ((s % 2) == 0);
         #1;
         n_checks++; if (bus_m.tx_valid !== 1'b1) begin n_fail++; $display("FAIL msb_valid s=%0d got %b exp 1", s, bus_m.tx_valid); end
         n_checks++; if (bus_m.tx_data !== e_d[s]) begin n_fail++; $display("FAIL msb_data s=%0d got %h exp %h", s, bus_m.tx_data, e_d[s]); end
         @(negedge r_clk);
      end
      #1;
      n_checks++; if (bus_m.tx_valid !== 1'b0) begin n_fail++; $display("FAIL msb_end_valid got %b exp 0", bus_m.tx_valid); end
      n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL msb_end_busy got %b exp 0", busy_m); end
      n_checks++; if (words_sent_m !== 16'd1) begin n_fail++; $display("FAIL msb_words got %0d exp 1", words_sent_m); end
   endtask

   task automatic test_back_to_back();
      logic [13:0] e_ren = 14'b00_0000_0100_0001;
      logic [13:0] e_val = 14'b01_1110_0111_1000;
      logic [7:0]  e_d [14] = '{8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                8'h00, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55, 8'h00};
      @(negedge r_clk);
      mem[1] = 32'h11223344;
      mem[2] = 32'h55667788;
      wp = 3;
      bus.tx_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         #1;
         n_checks++; if (bus.fifo_ren !== e_ren[c]) begin n_fail++; $display("FAIL b2b_ren c=%0d got %b exp %b", c, bus.fifo_ren, e_ren[c]); end
         n_checks++; if (bus.tx_valid !== e_val[c]) begin n_fail++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, bus.tx_valid, e_val[c]); end
         if (e_val[c]) begin
            n_checks++; if (bus.tx_data !== e_d[c]) begin n_fail++; $display("FAIL b2b_data c=%0d got %h exp %h", c, bus.tx_data, e_d[c]); end
         end
         if (c < 13) @(negedge r_clk);
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b exp 0", busy); end
      n_checks++; if (words_sent !== 16'd3) begin n_fail++; $display("FAIL b2b_words got %0d exp 3", words_sent); end
   endtask

   task automatic test_en_drop();
      logic [7:0] e_val = 8'b0111_1000;
      logic [7:0] e_d [8] = '{8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00};
      @(negedge r_clk);
      mem[3] = 32'hCAFEF00D;
      mem[4] = 32'h0BADBEEF;
      wp = 5;
      for (int c = 0; c < 8; c++) begin
         if (c == 5) en = 1'b0;
         #1;
         n_checks++; if (bus.tx_valid !== e_val[c]) begin n_fail++; $display("FAIL endrop_valid c=%0d got %b exp %b", c, bus.tx_valid, e_val[c]); end
         if (e_val[c]) begin
            n_checks++; if (bus.tx_data !== e_d[c]) begin n_fail++; $display("FAIL endrop_data c=%0d got %h exp %h", c, bus.tx_data, e_d[c]); end
         end
         if (c > 0) begin
            n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL endrop_ren c=%0d got %b exp 0", c, bus.fifo_ren); end
         end
         @(negedge r_clk);
      end
      repeat (4) @(negedge r_clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy got %b exp 0", busy); end
      n_checks++; if (words_sent !== 16'd4) begin n_fail++; $display("FAIL endrop_words got %0d exp 4", words_sent); end
      n_checks++; if (rp !== 4) begin n_fail++; $display("FAIL endrop_left rp got %0d exp 4", rp); end
   endtask

   task automatic test_reset_mid();
      @(negedge r_clk);
      en = 1'b1;
      repeat (5) @(negedge r_clk);
      #1;
      n_checks++; if (bus.tx_data !== 8'hAD) begin n_fail++; $display("FAIL rmid_idx2 got %h exp AD", bus.tx_data); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", bus.tx_valid); end
      n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h exp 00", bus.tx_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy); end
      n_checks++; if (words_sent !== 16'h0000) begin n_fail++; $display("FAIL rmid_words got %h exp 0000", words_sent); end
      n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL rmid_ren got %b exp 0", bus.fifo_ren); end
      repeat (2) @(negedge r_clk);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge r_clk);
         #1;
         n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after c=%0d valid got %b exp 0", c, bus.tx_valid); end
      end
   endtask

   task automatic test_empty_wrap();
      for (int c = 0; c < 100; c++) begin
         @(negedge r_clk);
         #1;
         n_checks++;
         if ({bus.fifo_ren, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_idle c=%0d ren/busy got %b exp 00", c, {bus.fifo_ren, busy});
            break;
         end
      end
      @(negedge r_clk);
      force dut.words_q = 16'hFFFF;
      #1;
      release dut.words_q;
      #1;
      n_checks++; if (words_sent !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp FFFF", words_sent); end
      @(negedge r_clk);
      mem[5] = 32'hDEADBEEF;
      wp = 6;
      repeat (8) @(negedge r_clk);
      #1;
      n_checks++; if (rp !== 6) begin n_fail++; $display("FAIL wrap_read rp got %0d exp 6", rp); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy got %b exp 0", busy); end
      n_checks++; if (words_sent !== 16'h0000) begin n_fail++; $display("FAIL wrap_words got %h exp 0000", words_sent); end
   endtask

   initial begin
      reset          = 1'b0;
      en             = 1'b0;
      bus.tx_ready   = 1'b0;
      bus_m.tx_ready = 1'b0;
      test_reset();
      test_lsb_word();
      test_msb_stall();
      test_back_to_back();
      test_en_drop();
      test_reset_mid();
      test_empty_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end
endmodule
